ifetch_page_walker: RTL

IFETCH_PAGE_WALKER -- requirements
Module: ifetch_page_walker

---
 rtl/ifetch_page_walker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_page_walker.sv
// ifetch_page_walker
//
// Turns one fetch PC into a short walk of line-aligned fetch addresses. The
// walk stays inside the PC's page. With translation enabled, the virtual page
// is looked up once through the TLB request/response ports. The walk then
// issues up to BURST lines, or runs to the page end when BURST is 0. The walk
// also ends at the page end whatever BURST says.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/req_pc   new fetch PC offered; req_ready accepts it (IDLE only)
//   flush              abort the walk in progress
//   tlb_req_*          page lookup request (vpn), valid/ready handshake
//   tlb_rsp_*          lookup result: ppn or fault
//   iss_*              line-aligned VA/PA per fetch line, valid/ready;
//                      iss_first marks the first line of a request
//   fault, fault_va    one-cycle fault pulse; the faulting VA stays held
//   page_end           pulses with the handshake of the last line of a page
//   busy               walker is not idle
module ifetch_page_walker #(
    parameter int VA_W       = 32,
    parameter int PA_W       = 32,
    parameter int PAGE_SHIFT = 12,
    parameter int LINE_SHIFT = 4,
    parameter int BURST      = 4,
    parameter int XLATE_EN   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [VA_W-1:0]            req_pc,
    output logic                       req_ready,
    input  logic                       flush,
    output logic                       tlb_req_valid,
    output logic [VA_W-PAGE_SHIFT-1:0] tlb_req_vpn,
    input  logic                       tlb_req_ready,
    input  logic                       tlb_rsp_valid,
    input  logic [PA_W-PAGE_SHIFT-1:0] tlb_rsp_ppn,
    input  logic                       tlb_rsp_fault,
    output logic                       iss_valid,
    output logic [VA_W-1:0]            iss_va,
    output logic [PA_W-1:0]            iss_pa,
    output logic                       iss_first,
    input  logic                       iss_ready,
    output logic                       fault,
    output logic [VA_W-1:0]            fault_va,
    output logic                       page_end,
    output logic                       busy
);

    // The counter must reach 2^(PAGE_SHIFT-LINE_SHIFT) after the last line of a full page.
    localparam int CNT_W = PAGE_SHIFT - LINE_SHIFT + 1;
    localparam logic [VA_W-1:0] LINE_BYTES = {{(VA_W-1){1'b0}}, 1'b1} << LINE_SHIFT;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TREQ  = 3'd1,
        TWAIT = 3'd2,
        ISSUE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [VA_W-1:0]            cur_va;
    logic [CNT_W-1:0]           cnt;
    logic [PA_W-PAGE_SHIFT-1:0] ppn;
    logic                       fault_q;

    logic accept;
    logic iss_hs;
    logic last_line;
    logic burst_done;
    logic rsp_take;

    assign accept     = req_valid & req_ready;
    assign iss_hs     = iss_valid & iss_ready;
    assign last_line  = &cur_va[PAGE_SHIFT-1:LINE_SHIFT];
    assign burst_done = (BURST != 0) && ((int'(cnt) + 1) == BURST);
    // A response that arrives together with a flush is consumed and dropped.
    assign rsp_take   = (state == TWAIT) & tlb_rsp_valid & ~flush;

    assign tlb_req_vpn = cur_va[VA_W-1:PAGE_SHIFT];
    assign iss_va      = cur_va;
    assign fault       = fault_q;

    generate
        if (XLATE_EN != 0) begin : g_xlate
            assign iss_pa = {ppn, cur_va[PAGE_SHIFT-1:0]};
        end else begin : g_flat
            assign iss_pa = PA_W'(cur_va);
            logic unused_ppn;
            assign unused_ppn = ^ppn;
        end
    endgenerate

    // The low PC bits are discarded because the walk works in whole lines.
    logic unused_pc_lo;
    assign unused_pc_lo = ^req_pc[LINE_SHIFT-1:0];

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin : p_data
        if (rst) begin
            cur_va   <= '0;
            cnt      <= '0;
            ppn      <= '0;
            fault_va <= '0;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            if (accept) begin
                cur_va <= {req_pc[VA_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
                cnt    <= '0;
            end else if (iss_hs) begin
                // Handshakes in a flush cycle still count as delivered.
                cur_va <= cur_va + LINE_BYTES;
                cnt    <= cnt + 1'b1;
            end
            if (rsp_take && !tlb_rsp_fault) begin
                ppn <= tlb_rsp_ppn;
            end
            if (rsp_take && tlb_rsp_fault) begin
                fault_q  <= 1'b1;
                fault_va <= cur_va;
            end
        end
    end

    always_comb begin : p_next
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (XLATE_EN != 0) ? TREQ : ISSUE;
                end
            end
            TREQ: begin
                // A lookup accepted in the flush cycle still has a response in flight.
                if (flush) begin
                    state_nxt = tlb_req_ready ? HOLD : IDLE;
                end else if (tlb_req_ready) begin
                    state_nxt = TWAIT;
                end
            end
            TWAIT: begin
                if (tlb_rsp_valid) begin
                    state_nxt = (flush || tlb_rsp_fault) ? IDLE : ISSUE;
                end else if (flush) begin
                    state_nxt = HOLD;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (iss_hs && (last_line || burst_done)) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (tlb_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : p_out
        req_ready     = 1'b0;
        busy          = 1'b1;
        tlb_req_valid = 1'b0;
        iss_valid     = 1'b0;
        iss_first     = 1'b0;
        page_end      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = ~flush;
            end
            TREQ: begin
                tlb_req_valid = (XLATE_EN != 0);
            end
            ISSUE: begin
                iss_valid = 1'b1;
                iss_first = (cnt == '0);
                page_end  = iss_ready & last_line;
            end
            default: ;
        endcase
    end

endmodule
